// File: rtl/regbank_access_ctrl_if.sv
// Bundle of requester-side handshake and register-bank port signals for regbank_access_ctrl.
// The slave modport is the controller; the master modport is the surrounding requesters and bank.
interface regbank_access_ctrl_if #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 8
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rdata;
  logic               clr_start;
  logic               clr_busy;
  logic               rb_we;
  logic [AW-1:0]      rb_waddr;
  logic [DW-1:0]      rb_wdata;
  logic [AW-1:0]      rb_raddr;
  logic [DW-1:0]      rb_rdata;

  modport master (
    output req, req_wr, req_addr, req_wdata, clr_start, rb_rdata,
    input  ack, rdata, clr_busy, rb_we, rb_waddr, rb_wdata, rb_raddr
  );

  modport slave (
    input  req, req_wr, req_addr, req_wdata, clr_start, rb_rdata,
    output ack, rdata, clr_busy, rb_we, rb_waddr, rb_wdata, rb_raddr
  );
endinterface

// File: rtl/regbank_access_ctrl.sv
// Round-robin arbitrated req/ack access to a small register bank, with a clear sequencer
// that zeroes every entry. All outputs come straight from registers.
module regbank_access_ctrl #(
  parameter int NREQ = 4,
  parameter int AW   = 3,
  parameter int DW   = 8
) (
  input logic                  clk,
  input logic                  reset,
  regbank_access_ctrl_if.slave bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, CLEAR} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] last_grant, last_grant_nxt;
  logic [GW-1:0] gnt, gnt_nxt;
  logic          wr, wr_nxt;
  logic          clr_pend, clr_pend_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;

  logic            we_q, we_nxt;
  logic [AW-1:0]   waddr_q, waddr_nxt;
  logic [DW-1:0]   wdata_q, wdata_nxt;
  logic [AW-1:0]   raddr_q, raddr_nxt;
  logic [NREQ-1:0] ack_q, ack_nxt;
  logic [DW-1:0]   rdata_q, rdata_nxt;
  logic            busy_q, busy_nxt;

  logic [AW-1:0] addr_arr  [NREQ];
  logic [DW-1:0] wdata_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = bus.req_addr[i*AW +: AW];
    assign wdata_arr[i] = bus.req_wdata[i*DW +: DW];
  end

  // Round-robin search starting just after the most recent grant.
  logic          pick_valid;
  logic [GW-1:0] pick;
  logic [GW-1:0] idx;

  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    idx        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = GW'((int'(last_grant) + k) % NREQ);
      if (!pick_valid && bus.req[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    gnt_nxt        = gnt;
    wr_nxt         = wr;
    clr_pend_nxt   = clr_pend;
    clr_cnt_nxt    = clr_cnt;
    we_nxt         = 1'b0;
    waddr_nxt      = '0;
    wdata_nxt      = '0;
    raddr_nxt      = raddr_q;
    ack_nxt        = '0;
    rdata_nxt      = rdata_q;
    busy_nxt       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.clr_start || clr_pend) begin
          state_nxt    = CLEAR;
          clr_pend_nxt = 1'b0;
          clr_cnt_nxt  = '0;
          we_nxt       = 1'b1;
          busy_nxt     = 1'b1;
        end else if (pick_valid) begin
          state_nxt      = ACCESS;
          gnt_nxt        = pick;
          last_grant_nxt = pick;
          wr_nxt         = bus.req_wr[pick];
          raddr_nxt      = addr_arr[pick];
          if (bus.req_wr[pick]) begin
            we_nxt    = 1'b1;
            waddr_nxt = addr_arr[pick];
            wdata_nxt = wdata_arr[pick];
          end
        end
      end

      ACCESS: begin
        state_nxt = DONE;
        ack_nxt   = NREQ'(1) << gnt;
        if (!wr) rdata_nxt = bus.rb_rdata;
        if (bus.clr_start) clr_pend_nxt = 1'b1;
      end

      DONE: begin
        state_nxt = IDLE;
        if (bus.clr_start) clr_pend_nxt = 1'b1;
      end

      CLEAR: begin
        // clr_start is deliberately ignored here; a clear is already running.
        if (clr_cnt == '1) begin
          state_nxt = IDLE;
        end else begin
          clr_cnt_nxt = clr_cnt + AW'(1);
          we_nxt      = 1'b1;
          waddr_nxt   = clr_cnt + AW'(1);
          busy_nxt    = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GW'(NREQ - 1);
      gnt        <= '0;
      wr         <= 1'b0;
      clr_pend   <= 1'b0;
      clr_cnt    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      raddr_q    <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      gnt        <= gnt_nxt;
      wr         <= wr_nxt;
      clr_pend   <= clr_pend_nxt;
      clr_cnt    <= clr_cnt_nxt;
      we_q       <= we_nxt;
      waddr_q    <= waddr_nxt;
      wdata_q    <= wdata_nxt;
      raddr_q    <= raddr_nxt;
      ack_q      <= ack_nxt;
      rdata_q    <= rdata_nxt;
      busy_q     <= busy_nxt;
    end
  end

  assign bus.rb_we    = we_q;
  assign bus.rb_waddr = waddr_q;
  assign bus.rb_wdata = wdata_q;
  assign bus.rb_raddr = raddr_q;
  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign bus.clr_busy = busy_q;
endmodule
